// File: rtl/mpnc_dual_port_cache_if.sv
// mpnc_dual_port_cache_if: bundles the two CPU word ports and the single
// physical-memory line port of the dual-port cache.
// Ports: slave = the cache side, master = the CPUs plus the memory model.
interface mpnc_dual_port_cache_if;
  logic [1:0]       d_mem_read;
  logic [1:0]       d_mem_write;
  logic [1:0][15:0] d_mem_address;
  logic [1:0][15:0] d_mem_wdata;
  logic [1:0][1:0]  d_mem_byte_enable;
  logic [1:0]       d_mem_resp;
  logic [1:0][15:0] d_mem_rdata;
  logic             pmem_read;
  logic             pmem_write;
  logic [15:0]      pmem_address;
  logic [255:0]     pmem_wdata;
  logic             pmem_resp;
  logic [255:0]     pmem_rdata;

  modport slave (
    input  d_mem_read, d_mem_write, d_mem_address, d_mem_wdata, d_mem_byte_enable,
    input  pmem_resp, pmem_rdata,
    output d_mem_resp, d_mem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output d_mem_read, d_mem_write, d_mem_address, d_mem_wdata, d_mem_byte_enable,
    output pmem_resp, pmem_rdata,
    input  d_mem_resp, d_mem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/mpnc_dual_port_cache.sv
// mpnc_dual_port_cache: two-port write-back, write-allocate L1 data cache,
// 2 ways x 8 sets x 32-byte lines, round-robin between the two CPU ports.
// Ports: clk, rst_n (async active-low), bus (slave modport: CPU ports + pmem).
// Hit responds one cycle after the request is taken; the other port waits.
module mpnc_dual_port_cache (
  input  logic                  clk,
  input  logic                  rst_n,
  mpnc_dual_port_cache_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, ALLOCATE} state_t;
  state_t state, state_nxt;

  // Per-way bit vectors indexed by set.
  logic [7:0]   valid_q [2];
  logic [7:0]   dirty_q [2];
  logic [7:0]   lru_q;              // value = way to evict next
  logic [7:0]   tag_q   [2][8];
  logic [255:0] data_q  [2][8];

  // Latched request of the granted port.
  logic             last_q;
  logic             gnt_q;
  logic             wr_q;
  logic             victim_q;
  logic [15:1]      addr_q;
  logic [15:0]      wdata_q;
  logic [1:0]       be_q;
  logic [1:0][15:0] rdata_q;

  logic [1:0]   req;
  logic         gnt_sel;
  logic [2:0]   idx;
  logic [7:0]   tag;
  logic [7:0]   bit_ofs;
  logic         hit0, hit1, hit, hit_way, victim_sel;
  logic [255:0] hit_line;
  logic [15:0]  hit_word, merged_word;

  assign req      = bus.d_mem_read | bus.d_mem_write;
  // On contention the port that was not served last wins.
  assign gnt_sel  = (&req) ? ~last_q : req[1];

  assign idx      = addr_q[7:5];
  assign tag      = addr_q[15:8];
  assign bit_ofs  = {addr_q[4:1], 4'b0000};

  assign hit0     = valid_q[0][idx] && (tag_q[0][idx] == tag);
  assign hit1     = valid_q[1][idx] && (tag_q[1][idx] == tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_line = data_q[hit_way][idx];
  assign hit_word = hit_line[bit_ofs +: 16];

  assign merged_word = {be_q[1] ? wdata_q[15:8] : hit_word[15:8],
                        be_q[0] ? wdata_q[7:0]  : hit_word[7:0]};

  // Fill an empty way first; only then fall back to LRU.
  assign victim_sel = !valid_q[0][idx] ? 1'b0 :
                      (!valid_q[1][idx] ? 1'b1 : lru_q[idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.d_mem_resp   = 2'b00;
    bus.d_mem_rdata  = rdata_q;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = 16'h0000;
    bus.pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (|req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          bus.d_mem_resp[gnt_q] = 1'b1;
          if (!wr_q) bus.d_mem_rdata[gnt_q] = hit_word;
          state_nxt = IDLE;
        end else if (valid_q[victim_sel][idx] && dirty_q[victim_sel][idx]) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag_q[victim_q][idx], idx, 5'b00000};
        bus.pmem_wdata   = data_q[victim_q][idx];
        if (bus.pmem_resp) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {tag, idx, 5'b00000};
        if (bus.pmem_resp) state_nxt = LOOKUP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      wr_q       <= 1'b0;
      victim_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            gnt_q   <= gnt_sel;
            wr_q    <= bus.d_mem_write[gnt_sel];
            addr_q  <= bus.d_mem_address[gnt_sel][15:1];
            wdata_q <= bus.d_mem_wdata[gnt_sel];
            be_q    <= bus.d_mem_byte_enable[gnt_sel];
          end
        end
        LOOKUP: begin
          if (hit) begin
            lru_q[idx] <= ~hit_way;
            last_q     <= gnt_q;
            if (wr_q) dirty_q[hit_way][idx] <= 1'b1;
            else      rdata_q[gnt_q]        <= hit_word;
          end else begin
            victim_q <= victim_sel;
          end
        end
        WRITEBACK: begin
          if (bus.pmem_resp) dirty_q[victim_q][idx] <= 1'b0;
        end
        ALLOCATE: begin
          if (bus.pmem_resp) begin
            valid_q[victim_q][idx] <= 1'b1;
            dirty_q[victim_q][idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Array contents need no reset: valid bits gate every use. Writes only
  // happen in LOOKUP/ALLOCATE, which reset forces the FSM out of.
  always_ff @(posedge clk) begin
    if (state == LOOKUP && hit && wr_q)
      data_q[hit_way][idx][bit_ofs +: 16] <= merged_word;
    if (state == ALLOCATE && bus.pmem_resp) begin
      data_q[victim_q][idx] <= bus.pmem_rdata;
      tag_q[victim_q][idx]  <= tag;
    end
  end

endmodule

// File: tb/tb_mpnc_dual_port_cache.sv
// tb_mpnc_dual_port_cache: directed + randomized bench for the dual-port cache.
// The CPU-visible memory image is a flat word map; backing memory is a line map.
// Memory model answers pmem requests after a fixed or random latency.
`timescale 1ns/1ps
module tb_mpnc_dual_port_cache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mpnc_dual_port_cache_if bus();
  mpnc_dual_port_cache dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference memory image (word granular) ----------------
  function automatic logic [15:0] dflt_word(input logic [15:0] a);
    logic [15:0] t;
    t = {a[15:1], 1'b0} * 16'd40503;
    return t ^ 16'h5AC3;
  endfunction

  logic [15:0]  img      [logic [14:0]];
  logic [255:0] pm_store [logic [10:0]];

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (img.exists(a[15:1])) return img[a[15:1]];
    return dflt_word(a);
  endfunction

  task automatic ref_wr(input logic [15:0] a, input logic [15:0] w, input logic [1:0] b);
    logic [15:0] o;
    o = ref_rd(a);
    img[a[15:1]] = {b[1] ? w[15:8] : o[15:8], b[0] ? w[7:0] : o[7:0]};
  endtask

  function automatic logic [255:0] line_rd(input logic [10:0] la);
    logic [255:0] l;
    if (pm_store.exists(la)) return pm_store[la];
    for (int w = 0; w < 16; w++) l[16*w +: 16] = dflt_word({la, 5'b0} + 16'(2*w));
    return l;
  endfunction

  // ---------------- physical memory model ----------------
  int fill_lat = 2;            // 0 selects a random latency of 1..4
  int wait_cnt = 0;
  int cur_lat  = 1;
  int pm_rd_cnt = 0;
  int pm_wr_cnt = 0;
  logic [15:0]  held_addr;
  logic [255:0] held_wdata;
  logic         ev_wr   [$];
  logic [15:0]  ev_addr [$];
  logic [255:0] ev_data [$];

  initial begin
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || bus.pmem_resp) begin
        bus.pmem_resp = 1'b0;
        wait_cnt = 0;
      end else if (bus.pmem_read || bus.pmem_write) begin
        if (wait_cnt == 0) begin
          cur_lat    = (fill_lat == 0) ? int'($urandom_range(1, 4)) : fill_lat;
          held_addr  = bus.pmem_address;
          held_wdata = bus.pmem_wdata;
          check("pmem_rd_wr_exclusive", bus.pmem_read & bus.pmem_write, 0);
          check("pmem_addr_aligned", bus.pmem_address[4:0], 0);
        end else begin
          check("pmem_addr_stable", bus.pmem_address, held_addr);
          if (bus.pmem_write) check("pmem_wdata_stable", bus.pmem_wdata, held_wdata);
        end
        wait_cnt++;
        if (wait_cnt >= cur_lat) begin
          ev_wr.push_back(bus.pmem_write);
          ev_addr.push_back(bus.pmem_address);
          if (bus.pmem_write) begin
            pm_store[bus.pmem_address[15:5]] = bus.pmem_wdata;
            ev_data.push_back(bus.pmem_wdata);
            pm_wr_cnt++;
          end else begin
            bus.pmem_rdata = line_rd(bus.pmem_address[15:5]);
            ev_data.push_back(bus.pmem_rdata);
            pm_rd_cnt++;
          end
          bus.pmem_resp = 1'b1;
        end
      end
    end
  end

  // ---------------- CPU-side driver ----------------
  bit          model_last = 1'b1;          // most recently served port
  logic [15:0] model_rdata [2] = '{16'h0, 16'h0};
  logic [15:0] obs_rdata [2];
  int          lat_seen  [2];
  int          served    [$];

  task automatic do_reset();
    rst_n = 1'b0;
    bus.d_mem_read = '0;
    bus.d_mem_write = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_last = 1'b1;
    model_rdata = '{16'h0, 16'h0};
  endtask

  // Issues up to one request per port and runs until each is answered.
  // Called and returns 1ns after a rising edge.
  task automatic run_reqs(input logic [1:0] en, input logic [1:0] wr,
                          input logic [15:0] a0, input logic [15:0] a1,
                          input logic [15:0] w0, input logic [15:0] w1,
                          input logic [1:0] b0, input logic [1:0] b1);
    logic [15:0] a [2];
    logic [15:0] w [2];
    logic [1:0]  b [2];
    logic [1:0]  pend, done;
    int cyc;
    bit first_exp;
    a[0] = a0; a[1] = a1; w[0] = w0; w[1] = w1; b[0] = b0; b[1] = b1;
    first_exp = !model_last;
    served.delete();
    for (int p = 0; p < 2; p++) begin
      if (en[p]) begin
        bus.d_mem_read[p]        = !wr[p];
        bus.d_mem_write[p]       = wr[p];
        bus.d_mem_address[p]     = a[p];
        bus.d_mem_wdata[p]       = w[p];
        bus.d_mem_byte_enable[p] = b[p];
      end
    end
    pend = en;
    cyc = 0;
    while (pend != 2'b00 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      done = 2'b00;
      for (int p = 0; p < 2; p++) begin
        if (pend[p] && bus.d_mem_resp[p]) begin
          lat_seen[p] = cyc;
          served.push_back(p);
          if (wr[p]) begin
            ref_wr(a[p], w[p], b[p]);
          end else begin
            obs_rdata[p] = bus.d_mem_rdata[p];
            check($sformatf("rdata_p%0d_%h", p, a[p]), bus.d_mem_rdata[p], ref_rd(a[p]));
            model_rdata[p] = ref_rd(a[p]);
          end
          model_last = (p == 1);
          done[p] = 1'b1;
        end else begin
          check($sformatf("no_resp_p%0d", p), bus.d_mem_resp[p], 0);
          check($sformatf("rdata_hold_p%0d", p), bus.d_mem_rdata[p], model_rdata[p]);
        end
      end
      pend = pend & ~done;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (done[p]) begin
          bus.d_mem_read[p] = 1'b0;
          bus.d_mem_write[p] = 1'b0;
        end
      end
    end
    if (pend != 2'b00) check("req_timeout", pend, 0);
    bus.d_mem_read = '0;
    bus.d_mem_write = '0;
    if (en == 2'b11 && served.size() > 0) check("arb_first_port", served[0], first_exp);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int rd0, wr0;
  bit seen;
  logic [255:0] l0;

  initial begin
    bus.d_mem_read = '0;
    bus.d_mem_write = '0;
    bus.d_mem_address = '0;
    bus.d_mem_wdata = '0;
    bus.d_mem_byte_enable = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d_mem_resp", bus.d_mem_resp, 0);
    check("rst_d_mem_rdata", bus.d_mem_rdata, 0);
    check("rst_pmem_read", bus.pmem_read, 0);
    check("rst_pmem_write", bus.pmem_write, 0);
    check("rst_pmem_address", bus.pmem_address, 0);
    check("rst_pmem_wdata", bus.pmem_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cold read miss with a known memory word, then a hit.
    l0 = line_rd(11'h11A);
    l0[15:0] = 16'h1234;
    pm_store[11'h11A] = l0;
    img[15'h11A0] = 16'h1234;
    fill_lat = 2;
    rd0 = pm_rd_cnt; wr0 = pm_wr_cnt; ev_addr.delete();
    run_reqs(2'b01, 2'b00, 16'h2340, 16'h0, 16'h0, 16'h0, 2'b11, 2'b00);
    check("cold_rdata", obs_rdata[0], 16'h1234);
    check("cold_latency", lat_seen[0], 5);
    check("cold_fill_count", pm_rd_cnt - rd0, 1);
    check("cold_no_wb", pm_wr_cnt - wr0, 0);
    check("cold_fill_addr", ev_addr[0], 16'h2340);
    rd0 = pm_rd_cnt;
    run_reqs(2'b01, 2'b00, 16'h2340, 16'h0, 16'h0, 16'h0, 2'b11, 2'b00);
    check("hit_latency", lat_seen[0], 2);
    check("hit_no_fill", pm_rd_cnt - rd0, 0);

    // Two ports, two different lines: fills serialise, port 0 first.
    do_reset();
    rd0 = pm_rd_cnt; ev_addr.delete();
    run_reqs(2'b11, 2'b00, 16'h2340, 16'h6002, 16'h0, 16'h0, 2'b11, 2'b11);
    check("dual_first_port", served[0], 0);
    check("dual_fill_count", pm_rd_cnt - rd0, 2);
    check("dual_fill0_addr", ev_addr[0], 16'h2340);
    check("dual_fill1_addr", ev_addr[1], 16'h6000);
    rd0 = pm_rd_cnt;
    run_reqs(2'b11, 2'b00, 16'h2340, 16'h6002, 16'h0, 16'h0, 2'b11, 2'b11);
    check("dual_both_hit", pm_rd_cnt - rd0, 0);

    // Reset while the fill is outstanding.
    do_reset();
    fill_lat = 8;
    bus.d_mem_read[0] = 1'b1;
    bus.d_mem_address[0] = 16'h6002;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.pmem_read;
    end
    check("alloc_reached", seen, 1);
    rst_n = 1'b0;
    #1;
    check("abort_pmem_read", bus.pmem_read, 0);
    check("abort_pmem_address", bus.pmem_address, 0);
    check("abort_no_resp", bus.d_mem_resp, 0);
    do_reset();
    fill_lat = 2;
    rd0 = pm_rd_cnt;
    run_reqs(2'b01, 2'b00, 16'h6002, 16'h0, 16'h0, 16'h0, 2'b11, 2'b00);
    check("after_abort_misses", pm_rd_cnt - rd0, 1);

    // Simultaneous writes to one line, then simultaneous reads.
    rd0 = pm_rd_cnt; wr0 = pm_wr_cnt;
    run_reqs(2'b11, 2'b11, 16'h0000, 16'h0002, 16'h600d, 16'hdddd, 2'b11, 2'b11);
    check("wr_pair_one_fill", pm_rd_cnt - rd0, 1);
    check("wr_pair_no_wb", pm_wr_cnt - wr0, 0);
    run_reqs(2'b11, 2'b00, 16'h0000, 16'h0002, 16'h0, 16'h0, 2'b11, 2'b11);
    check("rd_pair_p0", obs_rdata[0], 16'h600d);
    check("rd_pair_p1", obs_rdata[1], 16'hdddd);
    check("rd_pair_hits", pm_rd_cnt - rd0, 1);

    // Low-byte-only write.
    run_reqs(2'b01, 2'b01, 16'h0004, 16'h0, 16'h1111, 16'h0, 2'b11, 2'b00);
    run_reqs(2'b10, 2'b10, 16'h0, 16'h0004, 16'h0, 16'hABCD, 2'b00, 2'b01);
    run_reqs(2'b01, 2'b00, 16'h0004, 16'h0, 16'h0, 16'h0, 2'b11, 2'b00);
    check("byte_en_merge", obs_rdata[0], 16'h11CD);

    // Dirty eviction of line 0x0000.
    run_reqs(2'b01, 2'b00, 16'h0100, 16'h0, 16'h0, 16'h0, 2'b11, 2'b00);
    ev_wr.delete(); ev_addr.delete(); ev_data.delete();
    run_reqs(2'b01, 2'b00, 16'h0200, 16'h0, 16'h0, 16'h0, 2'b11, 2'b00);
    check("evict_event_count", ev_wr.size(), 2);
    check("evict_first_is_wb", ev_wr[0], 1);
    check("evict_wb_addr", ev_addr[0], 16'h0000);
    check("evict_wb_word0", ev_data[0][15:0], 16'h600d);
    check("evict_wb_word1", ev_data[0][31:16], 16'hdddd);
    check("evict_wb_word2", ev_data[0][47:32], 16'h11CD);
    check("evict_then_fill", ev_wr[1], 0);
    check("evict_fill_addr", ev_addr[1], 16'h0200);
    run_reqs(2'b01, 2'b00, 16'h0000, 16'h0, 16'h0, 16'h0, 2'b11, 2'b00);
    check("evicted_data_back", obs_rdata[0], 16'h600d);

    // Randomized traffic over 4 tags x 2 sets, random memory latency.
    fill_lat = 0;
    for (int n = 0; n < 200; n++) begin
      logic [1:0]  ren, rwr, rb0, rb1;
      logic [15:0] ra [2];
      ren = 2'($urandom_range(1, 3));
      rwr = 2'($urandom_range(0, 3));
      rb0 = 2'($urandom_range(0, 3));
      rb1 = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++)
        ra[p] = 16'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 1) << 5) |
                    ($urandom_range(0, 15) << 1) | $urandom_range(0, 1));
      run_reqs(ren, rwr, ra[0], ra[1], 16'($urandom), 16'($urandom), rb0, rb1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
